// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the writeback stage and a
//   long-latency unit. Pipeline writes win and pass through combinationally.
//   Long-latency results wait in a one-entry buffer. A result blocked for
//   STARVE_LIMIT consecutive cycles takes a forced slot, and the pipeline is
//   stalled for that one cycle.
//
//   Optional feature: `define WB_ARB_WAW_SQUASH_EN to drop a buffered result
//   when the pipeline writes the same register while the result is held.
//
// Ports
//   CLK, RST                        clock, synchronous active-high reset
//   pipe_wen/pipe_wsel/pipe_wdat    writeback-stage write request
//   lu_valid/lu_wsel/lu_wdat        long-latency result offer
//   lu_ready                        buffer can accept (lu_valid && lu_ready = transfer)
//   stall_pipe                      writeback must hold and re-present its write
//   WEN/wsel/wdat                   register-file write port
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_wsel,
    input  logic [31:0] pipe_wdat,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wsel,
    input  logic [31:0] lu_wdat,
    output logic        lu_ready,
    output logic        stall_pipe,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_buf_wsel;
    logic [31:0]   r_buf_wdat;

    logic          w_port_free;
    logic          w_squash;
    logic [CW-1:0] w_cnt_inc;

    // A pipe write to r0 does not occupy the port, so a held result may drain.
    assign w_port_free = !pipe_wen || (pipe_wsel == '0);
    assign w_cnt_inc   = r_cnt + CW'(1);

`ifdef WB_ARB_WAW_SQUASH_EN
    assign w_squash = pipe_wen && (pipe_wsel == r_buf_wsel) && (pipe_wsel != '0);
`else
    assign w_squash = 1'b0;
`endif

    assign lu_ready   = !RST && (r_state == EMPTY);
    assign stall_pipe = (r_state == FORCE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= EMPTY;
            r_cnt      <= '0;
            r_buf_wsel <= '0;
            r_buf_wdat <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    // Results for r0 are accepted but never buffered.
                    if (lu_valid && (lu_wsel != '0)) begin
                        r_buf_wsel <= lu_wsel;
                        r_buf_wdat <= lu_wdat;
                        r_cnt      <= '0;
                        r_state    <= HELD;
                    end
                end
                HELD: begin
                    if (w_port_free) begin
                        r_state <= EMPTY;
                    end else if (w_squash) begin
                        r_state <= EMPTY;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CW'(STARVE_LIMIT)) begin
                            r_state <= FORCE;
                        end
                    end
                end
                FORCE: begin
                    r_state <= EMPTY;
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        WEN  = pipe_wen;
        wsel = pipe_wsel;
        wdat = pipe_wdat;
        if (r_state == FORCE) begin
            WEN  = 1'b1;
            wsel = r_buf_wsel;
            wdat = r_buf_wdat;
        end else if (pipe_wen && (pipe_wsel != '0)) begin
            WEN  = 1'b1;
            wsel = pipe_wsel;
            wdat = pipe_wdat;
        end else if (r_state == HELD) begin
            WEN  = 1'b1;
            wsel = r_buf_wsel;
            wdat = r_buf_wdat;
        end
        if (RST) begin
            WEN = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pipe_wen;
    logic [4:0]  pipe_wsel;
    logic [31:0] pipe_wdat;
    logic        lu_valid;
    logic [4:0]  lu_wsel;
    logic [31:0] lu_wdat;
    logic        lu_ready;
    logic        stall_pipe;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          c;
        logic [4:0]  sel;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pipe_wen   (pipe_wen),
        .pipe_wsel  (pipe_wsel),
        .pipe_wdat  (pipe_wdat),
        .lu_valid   (lu_valid),
        .lu_wsel    (lu_wsel),
        .lu_wdat    (lu_wdat),
        .lu_ready   (lu_ready),
        .stall_pipe (stall_pipe),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input logic [4:0] s, input logic [31:0] d);
        exp_t e;
        e.c   = c;
        e.sel = s;
        e.dat = d;
        q.push_back(e);
    endfunction

    task automatic pipe(input logic en, input logic [4:0] s, input logic [31:0] d);
        pipe_wen  = en;
        pipe_wsel = s;
        pipe_wdat = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] s, input logic [31:0] d);
        lu_valid = v;
        lu_wsel  = s;
        lu_wdat  = d;
    endtask

    // Check control outputs mid-cycle, then advance to just after the next edge.
    task automatic ctl(input string nm, input logic er, input logic es);
        @(negedge CLK);
        chk({nm, "/lu_ready"}, 32'(lu_ready), 32'(er));
        chk({nm, "/stall_pipe"}, 32'(stall_pipe), 32'(es));
        @(posedge CLK);
        #1;
    endtask

    // Write-port monitor: every write must match the next expected entry,
    // including the cycle it was expected in.
    always @(negedge CLK) begin
        if (WEN === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got wsel=%0d wdat=%0h expected no write (cycle %0d)",
                         wsel, wdat, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("write_cycle", 32'(cyc), 32'(e.c));
                chk("write_wsel", 32'(wsel), 32'(e.sel));
                chk("write_wdat", wdat, e.dat);
            end
        end else if (q.size() != 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_write: got WEN=%0b expected write r%0d=%0h in cycle %0d",
                     WEN, e.sel, e.dat, e.c);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles with both requesters active.
        RST = 1'b1;
        lu(1'b1, 5'd2, 32'h2222);
        pipe(1'b1, 5'd5, 32'h55);
        @(posedge CLK);
        #1;
        repeat (2) begin
            @(negedge CLK);
            chk("rst/WEN", 32'(WEN), 32'd0);
            chk("rst/lu_ready", 32'(lu_ready), 32'd0);
            chk("rst/stall_pipe", 32'(stall_pipe), 32'd0);
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
        lu(1'b0, 5'd0, 32'h0);
        push(cyc, 5'd5, 32'h55);
        ctl("release", 1'b1, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);

        // Idle drain.
        lu(1'b1, 5'd3, 32'hDEAD);
        push(cyc + 1, 5'd3, 32'hDEAD);
        ctl("idle_cap", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        ctl("idle_drain", 1'b0, 1'b0);
        ctl("idle_after", 1'b1, 1'b0);

        // Starvation: r7 blocked by r8..r12, forced in the 5th cycle after capture.
        lu(1'b1, 5'd7, 32'h777);
        pipe(1'b1, 5'd8, 32'd8);
        push(cyc, 5'd8, 32'd8);
        ctl("starve_cap", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        for (int i = 9; i <= 12; i++) begin
            pipe(1'b1, 5'(i), 32'(i));
            push(cyc, 5'(i), 32'(i));
            ctl("starve_block", 1'b0, 1'b0);
        end
        pipe(1'b1, 5'd13, 32'd13);
        push(cyc, 5'd7, 32'h777);
        ctl("starve_force", 1'b0, 1'b1);
        push(cyc, 5'd13, 32'd13);
        ctl("starve_replay", 1'b1, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);
        ctl("starve_idle", 1'b1, 1'b0);

        // Write-after-write on r9.
        lu(1'b1, 5'd9, 32'h1);
        ctl("waw_cap", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd9, 32'h2);
        push(cyc, 5'd9, 32'h2);
        ctl("waw_pipe", 1'b0, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_WAW_SQUASH_EN
        ctl("waw_after", 1'b1, 1'b0);
`else
        push(cyc, 5'd9, 32'h1);
        ctl("waw_drain", 1'b0, 1'b0);
        ctl("waw_after", 1'b1, 1'b0);
`endif

        // Register 0 handling.
        lu(1'b1, 5'd0, 32'hBAD);
        ctl("r0_xfer", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        ctl("r0_empty", 1'b1, 1'b0);
        lu(1'b1, 5'd4, 32'h44);
        ctl("r4_cap", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd0, 32'h99);
        push(cyc, 5'd4, 32'h44);
        ctl("r4_drain", 1'b0, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);
        ctl("r4_after", 1'b1, 1'b0);

        // Reset asserted in the FORCE cycle: buffered r6 is lost.
        lu(1'b1, 5'd6, 32'h66);
        pipe(1'b1, 5'd1, 32'h11);
        push(cyc, 5'd1, 32'h11);
        ctl("rf_cap", 1'b1, 1'b0);
        lu(1'b0, 5'd0, 32'h0);
        repeat (4) begin
            push(cyc, 5'd1, 32'h11);
            ctl("rf_block", 1'b0, 1'b0);
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("rf_force/WEN", 32'(WEN), 32'd0);
        chk("rf_force/lu_ready", 32'(lu_ready), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        pipe(1'b0, 5'd0, 32'h0);
        ctl("rf_post", 1'b1, 1'b0);
        ctl("rf_idle", 1'b1, 1'b0);

        @(negedge CLK);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
